cr_prefix_ob_fifo: RTL and testbench

- Elastic output buffer directly downstream of the prefix stage. It consumes the prefix outbound AXI4-stream datapath and re-presents it to the next engine.
- Adds frame accounting, optional store-and-forward gating, a synchronous flush, and single-cycle stat event pulses for the stats block.

---
 rtl/cr_prefix_ob_fifo_if.sv | 24 ++
 rtl/cr_prefix_ob_fifo.sv | 142 ++++++++++++++
 tb/tb_cr_prefix_ob_fifo.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cr_prefix_ob_fifo_if.sv
// AXI4-stream beat bundle shared by the inbound and outbound sides of the prefix output buffer.
// master drives the beat and valid, slave returns ready.
interface cr_prefix_ob_fifo_if #(
  parameter int DATA_W = 64,
  parameter int USER_W = 8
);
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;
  logic                  tid;
  logic [DATA_W/8-1:0]   tstrb;
  logic [USER_W-1:0]     tuser;
  logic [DATA_W-1:0]     tdata;

  modport master (
    output tvalid, tlast, tid, tstrb, tuser, tdata,
    input  tready
  );

  modport slave (
    input  tvalid, tlast, tid, tstrb, tuser, tdata,
    output tready
  );
endinterface

// File: rtl/cr_prefix_ob_fifo.sv
// Elastic output buffer behind the prefix stage: register-array FIFO with frame accounting,
// store-and-forward gating (PASS/HOLD/FORCE), synchronous flush and registered stat pulses.
module cr_prefix_ob_fifo #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 64,
  parameter int USER_W = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  cr_prefix_ob_fifo_if.slave           ib,
  cr_prefix_ob_fifo_if.master          ob,
  input  logic                         cfg_sf_mode,
  input  logic                         flush,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic [$clog2(DEPTH+1)-1:0]   frames_held,
  output logic                         stat_frame_in,
  output logic                         stat_frame_out,
  output logic                         stat_ob_stall,
  output logic                         stat_sf_overrun
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int LVL_W  = $clog2(DEPTH+1);
  localparam int STRB_W = DATA_W / 8;
  localparam int ENT_W  = 2 + STRB_W + USER_W + DATA_W;

  typedef enum logic [1:0] {
    ST_PASS  = 2'd0,
    ST_HOLD  = 2'd1,
    ST_FORCE = 2'd2
  } gate_e;

  gate_e              state, state_nxt;
  logic [ENT_W-1:0]   mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [LVL_W-1:0]   level_nxt, frames_nxt;
  logic               sf_q, sf_nxt;
  logic               head_sof, head_sof_nxt;
  logic               push, pop, stall, head_last, fr_in, fr_out;
  logic [ENT_W-1:0]   head_ent;

  // FORCE is only reachable from HOLD, when a frame has filled the buffer without its tlast.
  function automatic gate_e gate_rule(input logic sf, input logic [LVL_W-1:0] frames,
                                      input logic [LVL_W-1:0] lvl, input logic from_hold);
    if (!sf || frames != '0)
      return ST_PASS;
    else if (from_hold && lvl == LVL_W'(DEPTH))
      return ST_FORCE;
    else
      return ST_HOLD;
  endfunction

  assign head_ent  = mem[rd_ptr];
  assign head_last = head_ent[ENT_W-1];

  assign ib.tready = ~rst & ~flush & (level < LVL_W'(DEPTH));
  assign ob.tvalid = (level != '0) & (state != ST_HOLD);
  assign push      = ib.tvalid & ib.tready;
  assign pop       = ob.tvalid & ob.tready;
  assign stall     = ob.tvalid & ~ob.tready;
  assign fr_in     = push & ib.tlast;
  assign fr_out    = pop & head_last;

  // Fields are zeroed while not valid so reset/flush never expose stale storage.
  assign {ob.tlast, ob.tid, ob.tstrb, ob.tuser, ob.tdata} = ob.tvalid ? head_ent : '0;

  always_comb begin
    state_nxt    = state;
    sf_nxt       = sf_q;
    head_sof_nxt = head_sof;
    level_nxt    = level;
    frames_nxt   = frames_held;
    if (flush) begin
      level_nxt    = '0;
      frames_nxt   = '0;
      head_sof_nxt = 1'b1;
      sf_nxt       = cfg_sf_mode;
      state_nxt    = cfg_sf_mode ? ST_HOLD : ST_PASS;
    end else begin
      case ({push, pop})
        2'b10:   level_nxt = level + LVL_W'(1);
        2'b01:   level_nxt = level - LVL_W'(1);
        default: level_nxt = level;
      endcase
      if (fr_in && !fr_out)
        frames_nxt = frames_held + LVL_W'(1);
      else if (!fr_in && fr_out)
        frames_nxt = frames_held - LVL_W'(1);
      if (pop)
        head_sof_nxt = head_last;
      // A presented-but-stalled beat freezes the gate so ob_tvalid cannot retract.
      if (!stall) begin
        if (head_sof_nxt)
          sf_nxt = cfg_sf_mode;
        case (state)
          ST_FORCE: if (fr_out) state_nxt = gate_rule(sf_nxt, frames_nxt, level_nxt, 1'b0);
          ST_HOLD:  state_nxt = gate_rule(sf_nxt, frames_nxt, level_nxt, 1'b1);
          default:  state_nxt = gate_rule(sf_nxt, frames_nxt, level_nxt, 1'b0);
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= ST_PASS;
      sf_q            <= 1'b0;
      head_sof        <= 1'b1;
      level           <= '0;
      frames_held     <= '0;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      stat_frame_in   <= 1'b0;
      stat_frame_out  <= 1'b0;
      stat_ob_stall   <= 1'b0;
      stat_sf_overrun <= 1'b0;
    end else begin
      state       <= state_nxt;
      sf_q        <= sf_nxt;
      head_sof    <= head_sof_nxt;
      level       <= level_nxt;
      frames_held <= frames_nxt;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      end
      stat_frame_in   <= fr_in & ~flush;
      stat_frame_out  <= fr_out & ~flush;
      stat_ob_stall   <= stall & ~flush;
      stat_sf_overrun <= ~flush & (state != ST_FORCE) & (state_nxt == ST_FORCE);
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= {ib.tlast, ib.tid, ib.tstrb, ib.tuser, ib.tdata};
  end

endmodule

// File: tb/tb_cr_prefix_ob_fifo.sv
// Directed bench for cr_prefix_ob_fifo: a scoreboard queue filled at beat acceptance,
// a negedge monitor checking delivered beats and the per-cycle stat pulses.
module tb_cr_prefix_ob_fifo;
  localparam int DEPTH  = 8;
  localparam int DATA_W = 64;
  localparam int USER_W = 8;
  localparam int LVL_W  = $clog2(DEPTH+1);

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cfg_sf_mode = 1'b0;
  logic             flush = 1'b0;
  logic [LVL_W-1:0] level, frames_held;
  logic             stat_frame_in, stat_frame_out, stat_ob_stall, stat_sf_overrun;

  cr_prefix_ob_fifo_if #(.DATA_W(DATA_W), .USER_W(USER_W)) ib_if ();
  cr_prefix_ob_fifo_if #(.DATA_W(DATA_W), .USER_W(USER_W)) ob_if ();

  cr_prefix_ob_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W), .USER_W(USER_W)) dut (
    .clk             (clk),
    .rst             (rst),
    .ib              (ib_if),
    .ob              (ob_if),
    .cfg_sf_mode     (cfg_sf_mode),
    .flush           (flush),
    .level           (level),
    .frames_held     (frames_held),
    .stat_frame_in   (stat_frame_in),
    .stat_frame_out  (stat_frame_out),
    .stat_ob_stall   (stat_ob_stall),
    .stat_sf_overrun (stat_sf_overrun)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [81:0] exp_q [$];
  int          n_fin = 0, n_fout = 0, n_ovr = 0;
  logic        p_fin = 1'b0, p_fout = 1'b0, p_stall = 1'b0;
  logic [81:0] mon_got, mon_exp;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [81:0] mk(input logic [63:0] d, input logic last);
    return {last, d[0], d[7:0], d[15:8], d};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [63:0] d, input logic last, input int gap);
    logic ok;
    ok = 1'b0;
    ib_if.tvalid = 1'b1;
    ib_if.tdata  = d;
    ib_if.tlast  = last;
    ib_if.tid    = d[0];
    ib_if.tstrb  = d[7:0];
    ib_if.tuser  = d[15:8];
    for (int n = 0; n < 64; n++) begin
      @(negedge clk);
      if (ib_if.tready) begin
        ok = 1'b1;
        break;
      end
    end
    chk("accept", {95'd0, ok}, 96'd1);
    if (ok) exp_q.push_back(mk(d, last));
    step();
    ib_if.tvalid = 1'b0;
    ib_if.tlast  = 1'b0;
    repeat (gap) step();
  endtask

  task automatic drain();
    logic done;
    done = 1'b0;
    for (int n = 0; n < 100; n++) begin
      if (exp_q.size() == 0) begin
        done = 1'b1;
        break;
      end
      step();
    end
    chk("drain", {95'd0, done}, 96'd1);
  endtask

  // Monitor: delivered beats against the scoreboard, stat pulses against last cycle's events.
  initial begin
    forever begin
      @(negedge clk);
      if (stat_frame_in)   n_fin++;
      if (stat_frame_out)  n_fout++;
      if (stat_sf_overrun) n_ovr++;
      chk("stat_frame_in",  {95'd0, stat_frame_in},  {95'd0, p_fin & ~rst});
      chk("stat_frame_out", {95'd0, stat_frame_out}, {95'd0, p_fout & ~rst});
      chk("stat_ob_stall",  {95'd0, stat_ob_stall},  {95'd0, p_stall & ~rst});
      p_fin   = ~rst & ~flush & ib_if.tvalid & ib_if.tready & ib_if.tlast;
      p_fout  = ~rst & ~flush & ob_if.tvalid & ob_if.tready & ob_if.tlast;
      p_stall = ~rst & ~flush & ob_if.tvalid & ~ob_if.tready;
      if (!rst && !flush && ob_if.tvalid && ob_if.tready) begin
        mon_got = {ob_if.tlast, ob_if.tid, ob_if.tstrb, ob_if.tuser, ob_if.tdata};
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got %0h expected none", mon_got);
        end else begin
          mon_exp = exp_q.pop_front();
          chk("beat", {14'd0, mon_got}, {14'd0, mon_exp});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int s_fin, s_fout, s_ovr;
    ib_if.tvalid = 1'b0; ib_if.tlast = 1'b0; ib_if.tid = 1'b0;
    ib_if.tstrb = '0; ib_if.tuser = '0; ib_if.tdata = '0;
    ob_if.tready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ib_tready", {95'd0, ib_if.tready}, 96'd0);
    chk("rst_ob_tvalid", {95'd0, ob_if.tvalid}, 96'd0);
    chk("rst_level", {92'd0, level}, 96'd0);
    chk("rst_frames", {92'd0, frames_held}, 96'd0);
    chk("rst_ob_tdata", {32'd0, ob_if.tdata}, 96'd0);
    chk("rst_stats", {92'd0, stat_frame_in, stat_frame_out, stat_ob_stall, stat_sf_overrun}, 96'd0);
    rst = 1'b0;
    step();

    // Cut-through, 3-beat frame
    ob_if.tready = 1'b1;
    s_fin = n_fin; s_fout = n_fout;
    send(64'h11, 1'b0, 0);
    chk("ct_valid", {95'd0, ob_if.tvalid}, 96'd1);
    chk("ct_data0", {32'd0, ob_if.tdata}, 96'h11);
    chk("ct_level0", {92'd0, level}, 96'd1);
    send(64'h22, 1'b0, 0);
    chk("ct_data1", {32'd0, ob_if.tdata}, 96'h22);
    chk("ct_level1", {92'd0, level}, 96'd1);
    send(64'h33, 1'b1, 0);
    chk("ct_level2", {92'd0, level}, 96'd1);
    chk("ct_last", {95'd0, ob_if.tlast}, 96'd1);
    step();
    chk("ct_level_end", {92'd0, level}, 96'd0);
    step();
    chk("ct_fin_cnt", 96'(n_fin - s_fin), 96'd1);
    chk("ct_fout_cnt", 96'(n_fout - s_fout), 96'd1);

    // Backpressure: fill all 8 entries
    ob_if.tready = 1'b0;
    for (int i = 0; i < 8; i++) send(64'h5A00 + 64'(i), (i == 7), 0);
    chk("full_level", {92'd0, level}, 96'd8);
    chk("full_ib_tready", {95'd0, ib_if.tready}, 96'd0);
    chk("full_head", {32'd0, ob_if.tdata}, 96'h5A00);
    chk("full_frames", {92'd0, frames_held}, 96'd1);
    chk("full_stall", {95'd0, stat_ob_stall}, 96'd1);
    ob_if.tready = 1'b1;
    drain();
    chk("full_drain_level", {92'd0, level}, 96'd0);
    chk("full_drain_frames", {92'd0, frames_held}, 96'd0);

    // Store-and-forward, gapped 4-beat frame
    cfg_sf_mode = 1'b1;
    step(); step();
    send(64'hC1, 1'b0, 2);
    send(64'hC2, 1'b0, 2);
    send(64'hC3, 1'b0, 2);
    chk("sf_gated", {95'd0, ob_if.tvalid}, 96'd0);
    chk("sf_level3", {92'd0, level}, 96'd3);
    chk("sf_frames0", {92'd0, frames_held}, 96'd0);
    send(64'hC4, 1'b1, 0);
    chk("sf_frames1", {92'd0, frames_held}, 96'd1);
    chk("sf_release", {95'd0, ob_if.tvalid}, 96'd1);
    chk("sf_level4", {92'd0, level}, 96'd4);
    step(); step();
    chk("sf_consec_valid", {95'd0, ob_if.tvalid}, 96'd1);
    chk("sf_consec_level", {92'd0, level}, 96'd2);
    step(); step();
    chk("sf_done_level", {92'd0, level}, 96'd0);
    chk("sf_done_frames", {92'd0, frames_held}, 96'd0);

    // Store-and-forward overrun with a 10-beat frame
    s_ovr = n_ovr;
    for (int i = 0; i < 8; i++) send(64'hD0 + 64'(i), 1'b0, 0);
    chk("force_level", {92'd0, level}, 96'd8);
    chk("force_valid", {95'd0, ob_if.tvalid}, 96'd1);
    chk("force_pulse", {95'd0, stat_sf_overrun}, 96'd1);
    send(64'hD8, 1'b0, 0);
    send(64'hD9, 1'b1, 0);
    drain();
    step();
    chk("force_level_end", {92'd0, level}, 96'd0);
    chk("force_ovr_cnt", 96'(n_ovr - s_ovr), 96'd1);
    send(64'hE1, 1'b0, 0);
    chk("force_back_hold", {95'd0, ob_if.tvalid}, 96'd0);
    chk("force_hold_level", {92'd0, level}, 96'd1);
    flush = 1'b1;
    exp_q.delete();
    step();
    flush = 1'b0;
    chk("flush0_level", {92'd0, level}, 96'd0);

    // Flush with push and pop both requested
    ob_if.tready = 1'b0;
    send(64'hF1, 1'b1, 0);
    send(64'hF2, 1'b0, 0);
    send(64'hF3, 1'b0, 0);
    send(64'hF4, 1'b0, 0);
    send(64'hF5, 1'b0, 0);
    chk("pre_flush_level", {92'd0, level}, 96'd5);
    chk("pre_flush_frames", {92'd0, frames_held}, 96'd1);
    chk("pre_flush_valid", {95'd0, ob_if.tvalid}, 96'd1);
    ib_if.tvalid = 1'b1; ib_if.tdata = 64'hF6; ib_if.tlast = 1'b1;
    ob_if.tready = 1'b1;
    flush = 1'b1;
    exp_q.delete();
    #1;
    chk("flush_ib_tready", {95'd0, ib_if.tready}, 96'd0);
    step();
    flush = 1'b0;
    ib_if.tvalid = 1'b0; ib_if.tlast = 1'b0;
    chk("flush_level", {92'd0, level}, 96'd0);
    chk("flush_frames", {92'd0, frames_held}, 96'd0);
    chk("flush_valid", {95'd0, ob_if.tvalid}, 96'd0);
    chk("flush_stats", {92'd0, stat_frame_in, stat_frame_out, stat_ob_stall, stat_sf_overrun}, 96'd0);
    send(64'hA1, 1'b0, 0);
    send(64'hA2, 1'b1, 0);
    drain();
    chk("post_flush_level", {92'd0, level}, 96'd0);

    // Asynchronous reset mid-frame
    cfg_sf_mode = 1'b0;
    step();
    ob_if.tready = 1'b0;
    send(64'h9901, 1'b0, 0);
    send(64'h9902, 1'b0, 0);
    send(64'h9903, 1'b0, 0);
    chk("pre_rst_level", {92'd0, level}, 96'd3);
    #2;
    rst = 1'b1;
    exp_q.delete();
    #1;
    chk("arst_valid", {95'd0, ob_if.tvalid}, 96'd0);
    chk("arst_level", {92'd0, level}, 96'd0);
    chk("arst_ib_tready", {95'd0, ib_if.tready}, 96'd0);
    chk("arst_tdata", {32'd0, ob_if.tdata}, 96'd0);
    chk("arst_stall", {95'd0, stat_ob_stall}, 96'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    ob_if.tready = 1'b1;
    step();
    send(64'h7701, 1'b0, 0);
    chk("rst_new_level", {92'd0, level}, 96'd1);
    send(64'h7702, 1'b1, 0);
    drain();
    chk("rst_new_level_end", {92'd0, level}, 96'd0);
    chk("rst_new_frames_end", {92'd0, frames_held}, 96'd0);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
